// File: rtl/unitate_fetch_pkg.sv
// Shared definitions for the fetch stage and the downstream decode stage:
// widths, the end-of-program word, fetch states and instruction field layout.
package unitate_fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int OPERAND_W  = INSTR_W - OPCODE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [OPERAND_W-1:0] operand_of(input logic [INSTR_W-1:0] instr);
        return instr[OPERAND_W-1:0];
    endfunction

endpackage

// File: rtl/unitate_fetch_if.sv
// Bundle between the fetch stage (master) and its environment (slave):
// instruction memory on one side, decode handshake and redirect on the other.
interface unitate_fetch_if #(
    parameter int ADDR_W  = unitate_fetch_pkg::ADDR_W,
    parameter int INSTR_W = unitate_fetch_pkg::INSTR_W
);
    logic               enable;
    logic [ADDR_W-1:0]  address;
    logic [INSTR_W-1:0] instruction;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_target;
    logic               halted;

    modport master (
        input  enable, instruction, ir_ready, redirect, redirect_target,
        output address, ir, ir_pc, ir_valid, halted
    );

    modport slave (
        output enable, instruction, ir_ready, redirect, redirect_target,
        input  address, ir, ir_pc, ir_valid, halted
    );
endinterface

// File: rtl/unitate_fetch_numarator_pc.sv
// Program counter: load has priority over increment; increment wraps modulo 2^ADDR_W.
module numarator_pc #(
    parameter int                ADDR_W   = unitate_fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // next PC selection
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/unitate_fetch.sv
// Instruction fetch stage: owns the PC, registers the memory word into ir and
// offers it to decode over valid/ready; supports redirect and stops on HALT_WORD.
module unitate_fetch #(
    parameter int                 ADDR_W    = unitate_fetch_pkg::ADDR_W,
    parameter int                 INSTR_W   = unitate_fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0] HALT_WORD = unitate_fetch_pkg::HALT_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    unitate_fetch_if.master  bus
);
    import unitate_fetch_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;

    logic [ADDR_W-1:0]  pc_s;
    logic               pc_load_s;
    logic               pc_inc_s;
    logic               load_s;
    logic               accept_s;

    numarator_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (pc_load_s),
        .target_i (bus.redirect_target),
        .inc_i    (pc_inc_s),
        .pc_o     (pc_s)
    );

    assign accept_s = ir_valid_q & bus.ir_ready;
    assign load_s   = (state_q == RUN) & bus.enable & (~ir_valid_q | bus.ir_ready);

    // next state, instruction register and PC control
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        pc_load_s  = 1'b0;
        pc_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.redirect) begin
                    pc_load_s  = 1'b1;
                    ir_valid_d = 1'b0;
                    halted_d   = 1'b0;
                end else if (load_s) begin
                    if (bus.instruction == HALT_WORD) begin
                        // the halt word never reaches decode; PC stays on it
                        ir_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end else begin
                        ir_d       = bus.instruction;
                        ir_pc_d    = pc_s;
                        ir_valid_d = 1'b1;
                        pc_inc_s   = 1'b1;
                    end
                end else if (accept_s) begin
                    ir_valid_d = 1'b0;
                end else begin
                    ir_valid_d = ir_valid_q;
                end
            end
            HALT: begin
                if (bus.redirect) begin
                    pc_load_s  = 1'b1;
                    ir_valid_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = RUN;
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d    = IDLE;
                ir_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ir_q       <= {INSTR_W{1'b0}};
            ir_pc_q    <= {ADDR_W{1'b0}};
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.address  = pc_s;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_unitate_fetch.sv
// Bench for unitate_fetch: directed vector tables for the documented scenarios,
// then random traffic checked against a rule-level model of the fetch stage.
module tb_unitate_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unitate_fetch_if bus ();
    unitate_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] mem [256];
    assign bus.instruction = mem[bus.address];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [7:0]  tgt;
        logic [7:0]  e_addr;
        logic [15:0] e_ir;
        logic [7:0]  e_irpc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t tab_a [9];
    vec_t tab_b [19];

    // model state
    bit          m_started, m_halted, m_valid;
    int          m_pc, m_irpc;
    logic [15:0] m_ir;

    task automatic check(input string name, input logic [7:0] ea, input logic [15:0] eir,
                         input logic [7:0] eirpc, input logic ev, input logic eh);
        total++;
        if ({bus.address, bus.ir, bus.ir_pc, bus.ir_valid, bus.halted} !== {ea, eir, eirpc, ev, eh}) begin
            bad++;
            $display("FAIL %s: got addr=%0d ir=%h ir_pc=%0d valid=%b halted=%b, want addr=%0d ir=%h ir_pc=%0d valid=%b halted=%b",
                     name, bus.address, bus.ir, bus.ir_pc, bus.ir_valid, bus.halted, ea, eir, eirpc, ev, eh);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic redir, input logic [7:0] tgt);
        bus.enable          = en;
        bus.ir_ready        = rdy;
        bus.redirect        = redir;
        bus.redirect_target = tgt;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        drive(v.en, v.rdy, v.redir, v.tgt);
        @(posedge clk);
        @(negedge clk);
        check(name, v.e_addr, v.e_ir, v.e_irpc, v.e_valid, v.e_halted);
    endtask

    task automatic load_plan_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'h012A; mem[1] = 16'h134B; mem[2] = 16'h256C; mem[3] = 16'h378D;
        mem[4] = 16'h5999; mem[5] = 16'h49AE; mem[6] = 16'h6BAB;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_started = 0; m_halted = 0; m_valid = 0;
        m_pc = 0; m_irpc = 0; m_ir = 16'h0000;
    endtask

    // one clock edge of the fetch rules, applied to the model
    task automatic model_step(input logic en, input logic rdy, input logic redir, input logic [7:0] tgt);
        if (!m_started) begin
            if (en) m_started = 1;
        end else if (redir) begin
            m_pc = int'(tgt);
            m_valid = 0;
            m_halted = 0;
        end else if (m_halted) begin
            m_halted = 1;
        end else if (en && (!m_valid || rdy)) begin
            if (mem[m_pc] == 16'hFFFF) begin
                m_halted = 1;
                m_valid = 0;
            end else begin
                m_ir = mem[m_pc];
                m_irpc = m_pc;
                m_valid = 1;
                m_pc = (m_pc + 1) % 256;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    initial begin
        tab_a[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 16'h0000, 8'd0, 1'b0, 1'b0};
        tab_a[1] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd1, 16'h012A, 8'd0, 1'b1, 1'b0};
        tab_a[2] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd2, 16'h134B, 8'd1, 1'b1, 1'b0};
        tab_a[3] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 16'h256C, 8'd2, 1'b1, 1'b0};
        tab_a[4] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd4, 16'h378D, 8'd3, 1'b1, 1'b0};
        tab_a[5] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd5, 16'h5999, 8'd4, 1'b1, 1'b0};
        tab_a[6] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd6, 16'h49AE, 8'd5, 1'b1, 1'b0};
        tab_a[7] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd7, 16'h6BAB, 8'd6, 1'b1, 1'b0};
        tab_a[8] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd7, 16'h6BAB, 8'd6, 1'b0, 1'b1};

        tab_b[0]  = '{1'b1, 1'b1, 1'b1, 8'd0,   8'd0,   16'h6BAB, 8'd6,   1'b0, 1'b0};
        tab_b[1]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b1, 1'b0};
        tab_b[2]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b1, 1'b0};
        tab_b[3]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b1, 1'b0};
        tab_b[4]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b1, 1'b0};
        tab_b[5]  = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd2,   16'h134B, 8'd1,   1'b1, 1'b0};
        tab_b[6]  = '{1'b1, 1'b1, 1'b1, 8'd5,   8'd5,   16'h134B, 8'd1,   1'b0, 1'b0};
        tab_b[7]  = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd6,   16'h49AE, 8'd5,   1'b1, 1'b0};
        tab_b[8]  = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd7,   16'h6BAB, 8'd6,   1'b1, 1'b0};
        tab_b[9]  = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd7,   16'h6BAB, 8'd6,   1'b0, 1'b1};
        tab_b[10] = '{1'b1, 1'b1, 1'b1, 8'd2,   8'd2,   16'h6BAB, 8'd6,   1'b0, 1'b0};
        tab_b[11] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd3,   16'h256C, 8'd2,   1'b1, 1'b0};
        tab_b[12] = '{1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 16'h256C, 8'd2,   1'b0, 1'b0};
        tab_b[13] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   16'h1234, 8'd255, 1'b1, 1'b0};
        tab_b[14] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b1, 1'b0};
        tab_b[15] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b1, 1'b0};
        tab_b[16] = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b0, 1'b0};
        tab_b[17] = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd1,   16'h012A, 8'd0,   1'b0, 1'b0};
        tab_b[18] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd2,   16'h134B, 8'd1,   1'b1, 1'b0};

        load_plan_mem();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        #3;
        check("reset_state", 8'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores redirect and fetches nothing while enable is low
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'd9);
            @(posedge clk);
            @(negedge clk);
            check("idle_hold", 8'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 9; i++) run_vec($sformatf("free_run_%0d", i), tab_a[i]);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("halt_stable_%0d", i), 8'd7, 16'h6BAB, 8'd6, 1'b0, 1'b1);
        end

        mem[255] = 16'h1234;
        for (int i = 0; i < 19; i++) run_vec($sformatf("seq_b_%0d", i), tab_b[i]);

        // asynchronous reset between edges while pc=4
        do_reset();
        for (int i = 0; i < 5; i++) run_vec($sformatf("pre_rst_%0d", i), tab_a[i]);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_vec($sformatf("restart_%0d", i), tab_a[i]);

        // random traffic against the model
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 15) == 0) mem[i] = 16'hFFFF;
            else mem[i] = 16'($urandom_range(0, 16'hFFFE));
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic en, rdy, redir;
            logic [7:0] tgt;
            en    = ($urandom_range(0, 7) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            tgt   = 8'($urandom_range(0, 255));
            drive(en, rdy, redir, tgt);
            model_step(en, rdy, redir, tgt);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("random_%0d", cyc), 8'(m_pc), m_ir, 8'(m_irpc), m_valid, m_halted);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
